// File: rtl/cr_cpu_pkg.sv
// Shared CPU definitions: instruction width and fetch-sequencer state encoding.
// No logic; latency and backpressure not applicable.
package cr_cpu_pkg;

   localparam int INSTR_WIDTH = 16;

   localparam logic [2:0] FS_BOOT    = 3'd0;
   localparam logic [2:0] FS_WAIT    = 3'd1;
   localparam logic [2:0] FS_CAPTURE = 3'd2;
   localparam logic [2:0] FS_HOLD    = 3'd3;
   localparam logic [2:0] FS_HALTED  = 3'd4;

   typedef enum logic [2:0] {
      ST_BOOT    = FS_BOOT,
      ST_WAIT    = FS_WAIT,
      ST_CAPTURE = FS_CAPTURE,
      ST_HOLD    = FS_HOLD,
      ST_HALTED  = FS_HALTED
   } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// PC register with load/increment and a synchronous-read program RAM (1 cycle after address change).
// Separate write port for program loading; no backpressure.
module program_counter
   import cr_cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_inc,
   input  logic                   i_load,
   input  logic [ADDR_WIDTH-1:0]  i_addr,
   output logic [ADDR_WIDTH-1:0]  o_addr,
   output logic [INSTR_WIDTH-1:0] o_instruction,
   input  logic                   i_wr_en,
   input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
   input  logic [INSTR_WIDTH-1:0] i_wr_data
);

   logic [INSTR_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [INSTR_WIDTH-1:0] r_instr;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Load wins over increment; wrap at 2^AW-1 is natural overflow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr  <= '0;
         r_instr <= '0;
      end else begin
         if (i_load) begin
            r_addr <= i_addr;
         end else if (i_inc) begin
            r_addr <= r_addr + 1'b1;
         end
         r_instr <= r_mem[r_addr];
      end
   end

   assign o_addr        = r_addr;
   assign o_instruction = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Drives program_counter, absorbs the 1-cycle RAM latency, holds the fetched word in IR.
// Boot/branch/resume to valid = 3 edges, 1 instr / 2 cycles; IR holds while i_ir_ready is low.
module fetch_sequencer
   import cr_cpu_pkg::*;
#(
   parameter int          ADDR_WIDTH   = 8,
   parameter int unsigned RESET_VECTOR = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic                   o_pc_inc,
   output logic                   o_pc_load,
   output logic [ADDR_WIDTH-1:0]  o_pc_load_addr,
   input  logic [ADDR_WIDTH-1:0]  i_pc_addr,
   input  logic [INSTR_WIDTH-1:0] i_instruction,
   output logic [INSTR_WIDTH-1:0] o_ir,
   output logic [ADDR_WIDTH-1:0]  o_ir_addr,
   output logic                   o_ir_valid,
   input  logic                   i_ir_ready,
   input  logic                   i_branch,
   input  logic [ADDR_WIDTH-1:0]  i_branch_addr,
   input  logic                   i_halt,
   input  logic                   i_resume,
   output logic                   o_halted,
   output logic [15:0]            o_fetch_count
);

   localparam logic [ADDR_WIDTH-1:0] LP_RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR);

   fetch_state_t            r_state;
   fetch_state_t            w_next;
   logic                    w_inc;
   logic                    w_load;
   logic [ADDR_WIDTH-1:0]   w_load_addr;
   logic                    w_hs;
   logic [INSTR_WIDTH-1:0]  r_ir;
   logic [ADDR_WIDTH-1:0]   r_ir_addr;
   logic                    r_ir_valid;
   logic [15:0]             r_fetch_count;

   assign w_hs = r_ir_valid & i_ir_ready & (r_state == ST_HOLD);

   always_comb begin
      w_next      = r_state;
      w_inc       = 1'b0;
      w_load      = 1'b0;
      w_load_addr = LP_RESET_VECTOR;
      case (r_state)
         ST_BOOT: begin
            w_load = 1'b1;
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_inc  = 1'b1;
            w_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_hs) begin
               // A taken branch throws away the prefetched word, so it must pass through WAIT.
               if (i_branch) begin
                  w_load      = 1'b1;
                  w_load_addr = i_branch_addr;
                  w_next      = i_halt ? ST_HALTED : ST_WAIT;
               end else begin
                  w_next      = i_halt ? ST_HALTED : ST_CAPTURE;
               end
            end
         end
         ST_HALTED: begin
            if (i_resume) begin
               w_next = ST_WAIT;
            end
         end
         default: begin
            w_next = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ir          <= '0;
         r_ir_addr     <= '0;
         r_ir_valid    <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         if (r_state == ST_CAPTURE) begin
            r_ir       <= i_instruction;
            r_ir_addr  <= i_pc_addr;
            r_ir_valid <= 1'b1;
         end else if (w_hs) begin
            r_ir_valid    <= 1'b0;
            r_fetch_count <= r_fetch_count + 16'd1;
         end
      end
   end

   // PC strobes are gated by reset so program_counter sees nothing while BOOT is held.
   assign o_pc_inc       = w_inc & ~i_rst;
   assign o_pc_load      = w_load & ~i_rst;
   assign o_pc_load_addr = w_load_addr;
   assign o_ir           = r_ir;
   assign o_ir_addr      = r_ir_addr;
   assign o_ir_valid     = r_ir_valid;
   assign o_halted       = (r_state == ST_HALTED);
   assign o_fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer beside program_counter: directed scenarios plus a randomized run
// against a transaction-level model of fetch order, latency, halt and fetch count.
module tb_fetch_sequencer;
   import cr_cpu_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        w_pc_inc, w_pc_load;
   logic [7:0]  w_pc_load_addr, w_pc_addr;
   logic [15:0] w_instr;
   logic [15:0] o_ir;
   logic [7:0]  o_ir_addr;
   logic        o_ir_valid, o_halted;
   logic [15:0] o_fetch_count;
   logic        i_ir_ready, i_branch, i_halt, i_resume;
   logic [7:0]  i_branch_addr;
   logic        i_wr_en;
   logic [7:0]  i_wr_addr;
   logic [15:0] i_wr_data;

   logic [15:0] prog [256];
   int vecs = 0;
   int errs = 0;

   always #5 i_clk = ~i_clk;

   program_counter #(.ADDR_WIDTH(8)) u_pc (
      .i_clk(i_clk), .i_rst(i_rst), .i_inc(w_pc_inc), .i_load(w_pc_load),
      .i_addr(w_pc_load_addr), .o_addr(w_pc_addr), .o_instruction(w_instr),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data)
   );

   fetch_sequencer #(.ADDR_WIDTH(8), .RESET_VECTOR(0)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .o_pc_inc(w_pc_inc), .o_pc_load(w_pc_load), .o_pc_load_addr(w_pc_load_addr),
      .i_pc_addr(w_pc_addr), .i_instruction(w_instr),
      .o_ir(o_ir), .o_ir_addr(o_ir_addr), .o_ir_valid(o_ir_valid), .i_ir_ready(i_ir_ready),
      .i_branch(i_branch), .i_branch_addr(i_branch_addr), .i_halt(i_halt), .i_resume(i_resume),
      .o_halted(o_halted), .o_fetch_count(o_fetch_count)
   );

   task automatic clear_inputs();
      i_ir_ready = 1'b0; i_branch = 1'b0; i_branch_addr = 8'h00;
      i_halt = 1'b0; i_resume = 1'b0;
   endtask

   // Program is written while the sequencer is held in reset.
   task automatic load_prog(input bit rnd);
      i_rst = 1'b1;
      clear_inputs();
      for (int i = 0; i < 256; i++) begin
         prog[i]   = rnd ? 16'($urandom) : 16'(i);
         i_wr_en   = 1'b1;
         i_wr_addr = 8'(i);
         i_wr_data = prog[i];
         @(negedge i_clk);
      end
      i_wr_en = 1'b0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      clear_inputs();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   // Consume instructions until the one at target sits in HOLD.
   task automatic run_to(input logic [7:0] target);
      bit found = 0;
      for (int n = 0; n < 600; n++) begin
         if (o_ir_valid && o_ir_addr == target) begin
            found = 1;
            break;
         end
         i_ir_ready = o_ir_valid;
         @(negedge i_clk);
      end
      i_ir_ready = 1'b0;
      vecs++;
      if (!found) begin errs++; $display("FAIL run_to_timeout: addr %h not reached, got %h", target, o_ir_addr); end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      clear_inputs();
      i_ir_ready = 1'b1;
      @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b exp 0", o_ir_valid); end
      vecs++; if (o_ir !== 16'h0) begin errs++; $display("FAIL rst_ir: got %h exp 0000", o_ir); end
      vecs++; if (o_ir_addr !== 8'h0) begin errs++; $display("FAIL rst_ir_addr: got %h exp 00", o_ir_addr); end
      vecs++; if (o_halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %b exp 0", o_halted); end
      vecs++; if (o_fetch_count !== 16'h0) begin errs++; $display("FAIL rst_count: got %h exp 0", o_fetch_count); end
      vecs++; if (w_pc_load !== 1'b0 || w_pc_inc !== 1'b0) begin errs++; $display("FAIL rst_pc_gate: got load=%b inc=%b exp 0 0", w_pc_load, w_pc_inc); end
      i_rst = 1'b0;
      #1;
      vecs++; if (w_pc_load !== 1'b1 || w_pc_load_addr !== 8'h00) begin errs++; $display("FAIL boot_load: got load=%b addr=%h exp 1 00", w_pc_load, w_pc_load_addr); end
      for (int e = 1; e <= 3; e++) begin
         @(negedge i_clk);
         vecs++; if (o_ir_valid !== (e == 3)) begin errs++; $display("FAIL boot_latency_e%0d: got valid=%b exp %b", e, o_ir_valid, e == 3); end
      end
      vecs++; if (o_ir !== 16'h0000 || o_ir_addr !== 8'h00) begin errs++; $display("FAIL boot_first: got ir=%h addr=%h exp 0000 00", o_ir, o_ir_addr); end
   endtask

   task automatic test_sequential();
      i_ir_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge i_clk);
         vecs++; if (o_ir_valid !== 1'b0) begin errs++; $display("FAIL seq_gap_%0d: got valid=%b exp 0", k, o_ir_valid); end
         @(negedge i_clk);
         vecs++; if (o_ir_valid !== 1'b1 || o_ir !== 16'(k) || o_ir_addr !== 8'(k)) begin
            errs++; $display("FAIL seq_word_%0d: got valid=%b ir=%h addr=%h exp 1 %h %h", k, o_ir_valid, o_ir, o_ir_addr, 16'(k), 8'(k)); end
      end
      @(negedge i_clk);
      vecs++; if (o_fetch_count !== 16'd4) begin errs++; $display("FAIL seq_count: got %0d exp 4", o_fetch_count); end
      i_ir_ready = 1'b0;
   endtask

   task automatic test_stall();
      logic [7:0] a;
      run_to(8'h04);
      a = 8'h04;
      i_ir_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         vecs++; if (o_ir_valid !== 1'b1 || o_ir_addr !== a || o_ir !== prog[a]) begin
            errs++; $display("FAIL stall_hold_%0d: got valid=%b addr=%h ir=%h exp 1 %h %h", c, o_ir_valid, o_ir_addr, o_ir, a, prog[a]); end
         vecs++; if (w_pc_addr !== a + 8'd1 || w_pc_inc !== 1'b0 || w_pc_load !== 1'b0) begin
            errs++; $display("FAIL stall_pc_%0d: got pc=%h inc=%b load=%b exp %h 0 0", c, w_pc_addr, w_pc_inc, w_pc_load, a + 8'd1); end
      end
      i_ir_ready = 1'b1;
      @(negedge i_clk);
      i_ir_ready = 1'b0;
      @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b1 || o_ir_addr !== a + 8'd1) begin
         errs++; $display("FAIL stall_release: got valid=%b addr=%h exp 1 %h", o_ir_valid, o_ir_addr, a + 8'd1); end
   endtask

   task automatic test_branch();
      do_reset();
      run_to(8'h03);
      i_ir_ready = 1'b1; i_branch = 1'b1; i_branch_addr = 8'h40;
      #1;
      vecs++; if (w_pc_load !== 1'b1 || w_pc_load_addr !== 8'h40) begin errs++; $display("FAIL br_load: got load=%b addr=%h exp 1 40", w_pc_load, w_pc_load_addr); end
      for (int e = 1; e <= 3; e++) begin
         @(negedge i_clk);
         i_branch = 1'b0;
         vecs++; if (o_ir_valid !== (e == 3)) begin errs++; $display("FAIL br_latency_e%0d: got valid=%b exp %b", e, o_ir_valid, e == 3); end
      end
      vecs++; if (o_ir_addr !== 8'h40 || o_ir !== prog[8'h40]) begin errs++; $display("FAIL br_target: got addr=%h ir=%h exp 40 %h", o_ir_addr, o_ir, prog[8'h40]); end
      i_ir_ready = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      run_to(8'h05);
      i_ir_ready = 1'b1; i_halt = 1'b1;
      @(negedge i_clk);
      i_ir_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         vecs++; if (o_halted !== 1'b1 || o_ir_valid !== 1'b0 || w_pc_addr !== 8'h06 || w_pc_inc !== 1'b0) begin
            errs++; $display("FAIL halt_state_%0d: got halted=%b valid=%b pc=%h inc=%b exp 1 0 06 0", c, o_halted, o_ir_valid, w_pc_addr, w_pc_inc); end
         @(negedge i_clk);
      end
      i_resume = 1'b1;
      @(negedge i_clk);
      i_resume = 1'b0;
      vecs++; if (o_halted !== 1'b0) begin errs++; $display("FAIL resume_clear: got %b exp 0", o_halted); end
      @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b0) begin errs++; $display("FAIL resume_early: got valid=%b exp 0", o_ir_valid); end
      @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b1 || o_ir_addr !== 8'h06) begin errs++; $display("FAIL resume_fetch: got valid=%b addr=%h exp 1 06", o_ir_valid, o_ir_addr); end
      // i_halt is still high: exactly one instruction, then halted again.
      i_ir_ready = 1'b1;
      @(negedge i_clk);
      i_ir_ready = 1'b0; i_halt = 1'b0;
      vecs++; if (o_halted !== 1'b1 || w_pc_addr !== 8'h07) begin errs++; $display("FAIL halt_again: got halted=%b pc=%h exp 1 07", o_halted, w_pc_addr); end
      i_resume = 1'b1;
      @(negedge i_clk);
      i_resume = 1'b0;
      repeat (2) @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b1 || o_ir_addr !== 8'h07) begin errs++; $display("FAIL resume2_fetch: got valid=%b addr=%h exp 1 07", o_ir_valid, o_ir_addr); end
   endtask

   task automatic test_branch_halt();
      i_ir_ready = 1'b1; i_branch = 1'b1; i_branch_addr = 8'h10; i_halt = 1'b1;
      @(negedge i_clk);
      clear_inputs();
      @(negedge i_clk);
      vecs++; if (o_halted !== 1'b1 || o_ir_valid !== 1'b0 || w_pc_addr !== 8'h10) begin
         errs++; $display("FAIL brhalt_state: got halted=%b valid=%b pc=%h exp 1 0 10", o_halted, o_ir_valid, w_pc_addr); end
      i_resume = 1'b1;
      @(negedge i_clk);
      i_resume = 1'b0;
      repeat (2) @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b1 || o_ir_addr !== 8'h10 || o_ir !== prog[8'h10]) begin
         errs++; $display("FAIL brhalt_resume: got valid=%b addr=%h ir=%h exp 1 10 %h", o_ir_valid, o_ir_addr, o_ir, prog[8'h10]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_to(8'h07);
      #2 i_rst = 1'b1;
      #1;
      vecs++; if (o_ir_valid !== 1'b0 || o_ir !== 16'h0 || o_ir_addr !== 8'h0 || o_fetch_count !== 16'h0 || o_halted !== 1'b0) begin
         errs++; $display("FAIL async_rst: got valid=%b ir=%h addr=%h cnt=%h halted=%b exp all zero", o_ir_valid, o_ir, o_ir_addr, o_fetch_count, o_halted); end
      vecs++; if (w_pc_inc !== 1'b0 || w_pc_load !== 1'b0) begin errs++; $display("FAIL async_rst_pc: got inc=%b load=%b exp 0 0", w_pc_inc, w_pc_load); end
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
      vecs++; if (o_ir_valid !== 1'b1 || o_ir_addr !== 8'h00 || o_ir !== prog[0]) begin
         errs++; $display("FAIL rst_refetch: got valid=%b addr=%h ir=%h exp 1 00 %h", o_ir_valid, o_ir_addr, o_ir, prog[0]); end
   endtask

   // Model: fetch order is addr+1 or branch target; valid appears 2 edges after a plain
   // handshake, 3 edges after boot/branch/resume; halt takes effect after its handshake.
   task automatic test_random();
      bit         m_valid = 0, m_halted = 0, hs;
      int         m_wait = 3;
      logic [7:0] m_addr = 8'h00;
      logic [15:0] m_count = 16'h0;
      load_prog(1'b1);
      i_rst = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         vecs++; if (o_ir_valid !== m_valid || o_halted !== m_halted || o_fetch_count !== m_count) begin
            errs++; $display("FAIL rnd_ctrl@%0d: got valid=%b halted=%b cnt=%0d exp %b %b %0d", cyc, o_ir_valid, o_halted, o_fetch_count, m_valid, m_halted, m_count); end
         if (m_valid) begin
            vecs++; if (o_ir_addr !== m_addr || o_ir !== prog[m_addr]) begin
               errs++; $display("FAIL rnd_ir@%0d: got addr=%h ir=%h exp %h %h", cyc, o_ir_addr, o_ir, m_addr, prog[m_addr]); end
         end
         i_ir_ready    = ($urandom_range(0, 3) != 0);
         i_branch      = ($urandom_range(0, 3) == 0);
         i_branch_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFD, 8'hFF)) : 8'($urandom);
         i_halt        = ($urandom_range(0, 9) == 0);
         i_resume      = ($urandom_range(0, 2) == 0);
         hs = m_valid && i_ir_ready;
         if (hs) begin
            m_count++;
            m_valid = 0;
            m_addr  = i_branch ? i_branch_addr : m_addr + 8'd1;
            m_wait  = i_halt ? 0 : (i_branch ? 3 : 2);
            m_halted = i_halt;
         end else if (m_halted && i_resume) begin
            m_halted = 0;
            m_wait   = 3;
         end
         if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1;
         end
         @(negedge i_clk);
      end
      clear_inputs();
   endtask

   initial begin
      i_rst = 1'b1;
      i_wr_en = 1'b0; i_wr_addr = 8'h00; i_wr_data = 16'h0;
      clear_inputs();
      load_prog(1'b0);
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_halt();
      test_branch_halt();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
